// File: rtl/tone_pkg.sv
// Shared types and widths for the sine tone player (ROM reader + 1-bit PWM renderer).
package tone_pkg;
  localparam int ROM_ADDR_W = 5;
  localparam int SAMPLE_W   = 4;
  localparam int PWM_W      = 4;
  localparam logic [PWM_W-1:0] PWM_MID = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } tone_state_t;
endpackage

// File: rtl/pwm_dac_4b.sv
// 4-bit PWM DAC: free-running frame counter, duty compare and registered output bit.
// TONE_MIDSCALE_IDLE_EN: when run=0 keep counting and emit a fixed 8/16 duty.
module pwm_dac_4b
  import tone_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_run,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_tick,
  output logic                o_pwm
);

  logic [PWM_W-1:0] r_cnt;
  logic             r_pwm;
  logic             w_count_en;
  logic             w_pwm_next;

`ifdef TONE_MIDSCALE_IDLE_EN
  assign w_count_en = 1'b1;
`else
  assign w_count_en = i_run;
`endif

  // Tick only matters while playing; an idle free-run must not advance the player.
  assign o_tick = i_run && (r_cnt == {PWM_W{1'b1}});

  // Duty compare for the next output bit.
  always_comb begin
    w_pwm_next = 1'b0;
    if (i_run) begin
      w_pwm_next = (r_cnt < i_sample);
    end else begin
`ifdef TONE_MIDSCALE_IDLE_EN
      w_pwm_next = (r_cnt < PWM_MID);
`else
      w_pwm_next = 1'b0;
`endif
    end
  end

  // Frame counter and registered PWM bit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_pwm <= 1'b0;
    end else begin
      r_cnt <= w_count_en ? (r_cnt + 4'd1) : 4'd0;
      r_pwm <= w_pwm_next;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/sine_tone_player.sv
// Sine ROM reader: phase accumulator steps the ROM address, one sample per PWM frame.
// Optional TONE_MIDSCALE_IDLE_EN gives an 8/16 idle duty instead of a silent low pin.
module sine_tone_player
  import tone_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_tw_load,
  input  logic [ACC_W-1:0]      i_tuning_word,
  output logic [ROM_ADDR_W-1:0] o_rom_addr,
  input  logic [SAMPLE_W-1:0]   i_rom_data,
  output logic                  o_audio_pwm,
  output logic                  o_sample_strobe,
  output logic                  o_busy
);

  tone_state_t             r_state;
  tone_state_t             w_next_state;
  logic [ACC_W-1:0]        r_acc;
  logic [ACC_W-1:0]        r_tw_shadow;
  logic [ACC_W-1:0]        r_tw_active;
  logic [SAMPLE_W-1:0]     r_sample_q;
  logic [ROM_ADDR_W-1:0]   r_rom_addr;
  logic                    r_strobe;
  logic                    r_busy;
  logic                    w_tick;
  logic                    w_run;
  logic                    w_latch;
  logic                    w_acc_add;
  logic                    w_acc_clr;

  assign w_run = (r_state != IDLE);

  pwm_dac_4b u_pwm (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (w_run),
    .i_sample (r_sample_q),
    .o_tick   (w_tick),
    .o_pwm    (o_audio_pwm)
  );

  // Next-state and datapath control decode.
  always_comb begin
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_acc_add    = 1'b0;
    w_acc_clr    = 1'b0;
    case (r_state)
      IDLE: begin
        w_acc_clr = 1'b1;
        if (i_enable) begin
          w_latch      = 1'b1;
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (w_tick) begin
          w_latch   = 1'b1;
          w_acc_add = 1'b1;
        end else begin
          w_latch   = 1'b0;
          w_acc_add = 1'b0;
        end
        if (!i_enable) begin
          w_next_state = STOP;
        end else begin
          w_next_state = RUN;
        end
      end
      STOP: begin
        if (w_tick) begin
          w_next_state = IDLE;
          w_acc_clr    = 1'b1;
        end else begin
          w_next_state = STOP;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_acc_clr    = 1'b1;
      end
    endcase
  end

  // State, accumulator, tuning registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_tw_shadow <= '0;
      r_tw_active <= '0;
      r_sample_q  <= '0;
      r_rom_addr  <= '0;
      r_strobe    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_acc_clr) begin
        r_acc <= '0;
      end else if (w_acc_add) begin
        r_acc <= r_acc + r_tw_active;
      end
      // Clearing with the accumulator keeps an immediate restart reading address 0.
      r_rom_addr <= w_acc_clr ? {ROM_ADDR_W{1'b0}} : r_acc[ACC_W-1 -: ROM_ADDR_W];
      if (i_tw_load) begin
        r_tw_shadow <= i_tuning_word;
      end
      if (w_latch) begin
        r_tw_active <= r_tw_shadow;
        r_sample_q  <= i_rom_data;
      end
      r_strobe <= w_latch;
      r_busy   <= (w_next_state != IDLE);
    end
  end

  assign o_rom_addr      = r_rom_addr;
  assign o_sample_strobe = r_strobe;
  assign o_busy          = r_busy;

endmodule
